clk_period_decoder: RTL and testbench

Measures the period of an incoming slow square wave (the programmable divided clock produced by the clock divider) and recovers the 3-bit program code that generated it. It is the decoding end of the divider: clock in, `prog` code out. Its `prog_out`/`update` pair is shaped so it can drive another divider's `prog`/`update` inputs directly. It sits next to the divider on the system clock and reports whether the divided clock is running at a legal rate.

---
 rtl/dcm_pkg.sv | 20 ++
 rtl/sync_edge.sv | 32 +++
 rtl/clk_period_decoder.sv | 150 +++++++++++++++
 tb/tb_clk_period_decoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcm_pkg.sv
// rtl/dcm_pkg.sv - shared types and nominal period table for the clock period decoder
package dcm_pkg;

    typedef logic [2:0] prog_t;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_MEAS = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam int NUM_CODES = 8;

    // Full periods of the divided clock for each program code, before scaling by DIV
    localparam logic [31:0] NOM [NUM_CODES] = '{
        32'd10000000,  32'd19999998,  32'd39999994,  32'd100000000,
        32'd160000000, 32'd319999998, 32'd639999994, 32'd1279999986
    };

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer plus delay flop with rising-edge detect
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/clk_period_decoder.sv
// rtl/clk_period_decoder.sv - measures a divided clock's period and recovers its program code
module clk_period_decoder
    import dcm_pkg::*;
#(
    parameter int unsigned DIV    = 1,
    parameter int unsigned TOL    = 64,
    parameter int unsigned LOCK_N = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_in,
    output logic [2:0] prog_out,
    output logic       valid,
    output logic       update,
    output logic       err
);

    localparam int          MW  = $clog2(LOCK_N + 1);
    localparam logic [31:0] TMO = NOM[NUM_CODES-1] / DIV + TOL;

    logic                 rise;
    logic [31:0]          cnt_q, cnt_d;
    logic [NUM_CODES-1:0] hit;
    prog_t                hit_code;
    logic                 any_hit;
    state_t               state_q, state_d;
    prog_t                cand_q, cand_d;
    logic [MW-1:0]        mcnt_q, mcnt_d;
    prog_t                prog_q, prog_d;
    logic                 valid_q, valid_d;
    logic                 update_q, update_d;
    logic                 err_q, err_d;

    sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (clk_in),
        .rise (rise)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = 32'd1;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    for (genvar k = 0; k < NUM_CODES; k++) begin : g_win
        localparam logic [31:0] PER = NOM[k] / DIV;
        localparam logic [31:0] LO  = (PER > TOL) ? PER - TOL : 32'd0;
        localparam logic [31:0] HI  = PER + TOL;
        assign hit[k] = (cnt_q >= LO) && (cnt_q <= HI);
    end

    // Scan downwards so the lowest matching code is the one left standing
    always_comb begin
        hit_code = '0;
        for (int k = NUM_CODES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                hit_code = prog_t'(k);
            end
        end
    end

    assign any_hit = |hit;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        mcnt_d   = mcnt_q;
        prog_d   = prog_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (rise) begin
                    state_d = ST_MEAS;
                    mcnt_d  = '0;
                end
            end
            ST_MEAS, ST_LOCK: begin
                if (rise) begin
                    if (!any_hit) begin
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        mcnt_d  = '0;
                        state_d = ST_MEAS;
                    end else if (state_q == ST_LOCK) begin
                        if (hit_code != cand_q) begin
                            valid_d = 1'b0;
                            cand_d  = hit_code;
                            mcnt_d  = MW'(1);
                            state_d = ST_MEAS;
                        end
                    end else begin
                        if (hit_code == cand_q) begin
                            mcnt_d = mcnt_q + MW'(1);
                        end else begin
                            cand_d = hit_code;
                            mcnt_d = MW'(1);
                        end
                        if (mcnt_d == MW'(LOCK_N)) begin
                            state_d  = ST_LOCK;
                            valid_d  = 1'b1;
                            prog_d   = hit_code;
                            update_d = 1'b1;
                        end
                    end
                end else if (cnt_q > TMO) begin
                    // Leaving for WAIT is what keeps this from firing again while cnt saturates
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            state_q  <= ST_WAIT;
            cand_q   <= '0;
            mcnt_q   <= '0;
            prog_q   <= '0;
            valid_q  <= 1'b0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            mcnt_q   <= mcnt_d;
            prog_q   <= prog_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            err_q    <= err_d;
        end
    end

    assign prog_out = prog_q;
    assign valid    = valid_q;
    assign update   = update_q;
    assign err      = err_q;

endmodule

// File: tb/tb_clk_period_decoder.sv
// tb/tb_clk_period_decoder.sv - self-checking bench for clk_period_decoder
module tb_clk_period_decoder;

    localparam int unsigned DIV    = 100000;
    localparam int unsigned TOL    = 2;
    localparam int unsigned LOCK_N = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_in;
    logic [2:0] prog_out;
    logic       valid;
    logic       update;
    logic       err;

    clk_period_decoder #(.DIV(DIV), .TOL(TOL), .LOCK_N(LOCK_N)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_in   (clk_in),
        .prog_out (prog_out),
        .valid    (valid),
        .update   (update),
        .err      (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int nom_tab [8] = '{10000000, 19999998, 39999994, 100000000,
                        160000000, 319999998, 639999994, 1279999986};
    int per_tab [8];
    int tmo_lim;

    int   step = 0;
    logic prev_in = 1'b0;
    int   rise_q[$];
    int   rise_log[$];

    // Reference model: 0 = waiting for first edge, 1 = measuring, 2 = locked
    int         m_state;
    int         m_cand;
    int         m_cnt;
    int         last_rise;
    logic [2:0] exp_prog;
    logic       exp_valid, exp_update, exp_err;

    int diff_cnt, first_diff, n_upd, n_err, both_cnt, first_upd, first_err;

    function automatic int classify(input int p);
        for (int k = 0; k < 8; k++) begin
            if (p >= per_tab[k] - int'(TOL) && p <= per_tab[k] + int'(TOL)) return k;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_state = 0; m_cand = 0; m_cnt = 0; last_rise = 0;
        exp_prog = 3'd0; exp_valid = 1'b0; exp_update = 1'b0; exp_err = 1'b0;
        rise_q.delete();
    endtask

    task automatic model_rise(input int p);
        int k;
        if (m_state == 0) begin
            m_state = 1;
            m_cnt   = 0;
            return;
        end
        k = classify(p);
        if (k < 0) begin
            exp_err = 1'b1; exp_valid = 1'b0; m_cnt = 0; m_state = 1;
        end else if (m_state == 2) begin
            if (k != m_cand) begin
                exp_valid = 1'b0; m_cand = k; m_cnt = 1; m_state = 1;
            end
        end else begin
            if (k == m_cand && m_cnt > 0) m_cnt++;
            else begin
                m_cand = k; m_cnt = 1;
            end
            if (m_cnt == int'(LOCK_N)) begin
                m_state = 2; exp_valid = 1'b1; exp_prog = 3'(k); exp_update = 1'b1;
            end
        end
    endtask

    task automatic tick(input logic v);
        int r;
        clk_in = v;
        if (v && !prev_in) begin
            rise_q.push_back(step + 3);
            rise_log.push_back(step + 1);
        end
        prev_in = v;
        @(posedge clk);
        #1;
        step++;
        exp_update = 1'b0;
        exp_err    = 1'b0;
        if (rst) begin
            model_clear();
        end else if (rise_q.size() > 0 && rise_q[0] == step) begin
            void'(rise_q.pop_front());
            r = step - 2;
            model_rise(r - last_rise);
            last_rise = r;
        end else if (m_state != 0 && (step - 2) - last_rise > tmo_lim) begin
            exp_err = 1'b1; exp_valid = 1'b0; m_state = 0;
        end
        if (valid !== exp_valid || update !== exp_update || err !== exp_err || prog_out !== exp_prog) begin
            if (first_diff < 0) first_diff = step;
            diff_cnt++;
        end
        if (update === 1'b1) begin
            n_upd++;
            if (first_upd < 0) first_upd = step;
        end
        if (err === 1'b1) begin
            n_err++;
            if (first_err < 0) first_err = step;
        end
        if (update === 1'b1 && err === 1'b1) both_cnt++;
    endtask

    task automatic begin_scn();
        diff_cnt = 0; first_diff = -1; n_upd = 0; n_err = 0;
        first_upd = -1; first_err = -1;
    endtask

    task automatic wave(input int p, input int n, input int hi);
        repeat (n) begin
            repeat (hi) tick(1'b1);
            repeat (p - hi) tick(1'b0);
        end
    endtask

    task automatic test_reset();
        begin_scn();
        rst = 1'b1;
        repeat (3) tick(1'b0);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", valid); end
        total++; if (prog_out !== 3'd0) begin bad++; $display("FAIL reset_prog got %0d want 0", prog_out); end
        total++; if (update !== 1'b0) begin bad++; $display("FAIL reset_update got %0b want 0", update); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %0b want 0", err); end
        rst = 1'b0;
        repeat (4) tick(1'b0);
        total++; if (diff_cnt !== 0) begin bad++; $display("FAIL reset_trace diffs %0d at step %0d want 0", diff_cnt, first_diff); end
    endtask

    task automatic test_lock();
        int base;
        begin_scn();
        base = rise_log.size();
        wave(1000, 4, 500);
        total++; if (n_upd !== 1) begin bad++; $display("FAIL lock_update_count got %0d want 1", n_upd); end
        total++; if (prog_out !== 3'd3) begin bad++; $display("FAIL lock_prog got %0d want 3", prog_out); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL lock_valid got %0b want 1", valid); end
        total++;
        if (first_upd - rise_log[base + 2] !== 2) begin
            bad++; $display("FAIL lock_latency got %0d want 2", first_upd - rise_log[base + 2]);
        end
        total++; if (diff_cnt !== 0) begin bad++; $display("FAIL lock_trace diffs %0d at step %0d want 0", diff_cnt, first_diff); end
    endtask

    task automatic test_relock();
        begin_scn();
        wave(199, 3, 100);
        total++; if (prog_out !== 3'd1) begin bad++; $display("FAIL relock_prog got %0d want 1", prog_out); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL relock_valid got %0b want 1", valid); end
        total++; if (n_upd !== 1) begin bad++; $display("FAIL relock_update_count got %0d want 1", n_upd); end
        total++; if (diff_cnt !== 0) begin bad++; $display("FAIL relock_trace diffs %0d at step %0d want 0", diff_cnt, first_diff); end
    endtask

    task automatic test_illegal();
        wave(1000, 3, 500);
        begin_scn();
        wave(500, 3, 250);
        total++; if (n_err !== 2) begin bad++; $display("FAIL illegal_err_count got %0d want 2", n_err); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL illegal_valid got %0b want 0", valid); end
        total++; if (prog_out !== 3'd3) begin bad++; $display("FAIL illegal_prog_hold got %0d want 3", prog_out); end
        total++; if (n_upd !== 0) begin bad++; $display("FAIL illegal_update_count got %0d want 0", n_upd); end
        total++; if (diff_cnt !== 0) begin bad++; $display("FAIL illegal_trace diffs %0d at step %0d want 0", diff_cnt, first_diff); end
    endtask

    task automatic test_tolerance();
        begin_scn();
        wave(1002, 3, 501);
        total++; if (valid !== 1'b1 || prog_out !== 3'd3) begin
            bad++; $display("FAIL tol_1002 got valid %0b prog %0d want 1/3", valid, prog_out);
        end
        begin_scn();
        wave(1003, 3, 501);
        total++; if (n_err !== 2 || valid !== 1'b0) begin
            bad++; $display("FAIL tol_1003 got err %0d valid %0b want 2/0", n_err, valid);
        end
        wave(98, 3, 49);
        total++; if (valid !== 1'b1 || prog_out !== 3'd0) begin
            bad++; $display("FAIL tol_98 got valid %0b prog %0d want 1/0", valid, prog_out);
        end
        begin_scn();
        wave(97, 2, 48);
        total++; if (n_err !== 1 || valid !== 1'b0) begin
            bad++; $display("FAIL tol_97 got err %0d valid %0b want 1/0", n_err, valid);
        end
        total++; if (diff_cnt !== 0) begin bad++; $display("FAIL tol_trace diffs %0d at step %0d want 0", diff_cnt, first_diff); end
    endtask

    task automatic test_timeout();
        int last_r;
        wave(1000, 3, 500);
        begin_scn();
        last_r = rise_log[rise_log.size() - 1];
        repeat (13000) tick(1'b0);
        total++; if (n_err !== 1) begin bad++; $display("FAIL timeout_err_count got %0d want 1", n_err); end
        total++;
        if (first_err - last_r !== tmo_lim + 3) begin
            bad++; $display("FAIL timeout_delay got %0d want %0d", first_err - last_r, tmo_lim + 3);
        end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL timeout_valid got %0b want 0", valid); end
        total++; if (prog_out !== 3'd3) begin bad++; $display("FAIL timeout_prog_hold got %0d want 3", prog_out); end
        wave(1000, 2, 500);
        total++; if (n_upd !== 0 || valid !== 1'b0) begin
            bad++; $display("FAIL timeout_wait got upd %0d valid %0b want 0/0", n_upd, valid);
        end
        wave(1000, 1, 500);
        total++; if (n_upd !== 1 || valid !== 1'b1) begin
            bad++; $display("FAIL timeout_relock got upd %0d valid %0b want 1/1", n_upd, valid);
        end
        total++; if (diff_cnt !== 0) begin bad++; $display("FAIL timeout_trace diffs %0d at step %0d want 0", diff_cnt, first_diff); end
    endtask

    task automatic test_reset_mid();
        begin_scn();
        repeat (500) tick(1'b1);
        repeat (300) tick(1'b0);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        total++; if ({valid, update, err, prog_out} !== 6'd0) begin
            bad++; $display("FAIL midreset_outputs got %06b want 000000", {valid, update, err, prog_out});
        end
        repeat (700) tick(1'b0);
        wave(1000, 2, 500);
        total++; if (n_upd !== 0 || valid !== 1'b0) begin
            bad++; $display("FAIL midreset_two_edges got upd %0d valid %0b want 0/0", n_upd, valid);
        end
        wave(1000, 1, 500);
        total++; if (valid !== 1'b1 || prog_out !== 3'd3) begin
            bad++; $display("FAIL midreset_relock got valid %0b prog %0d want 1/3", valid, prog_out);
        end
        total++; if (diff_cnt !== 0) begin bad++; $display("FAIL midreset_trace diffs %0d at step %0d want 0", diff_cnt, first_diff); end
    endtask

    task automatic test_random();
        int k, p, hi, n;
        begin_scn();
        both_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            k  = int'($urandom_range(0, 4));
            p  = per_tab[k] + int'($urandom_range(0, 8)) - 4;
            hi = int'($urandom_range(2, p - 2));
            n  = int'($urandom_range(1, 3));
            wave(p, n, hi);
        end
        total++; if (diff_cnt !== 0) begin bad++; $display("FAIL random_trace diffs %0d at step %0d want 0", diff_cnt, first_diff); end
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL random_update_err_overlap got %0d want 0", both_cnt); end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) per_tab[k] = nom_tab[k] / int'(DIV);
        tmo_lim = per_tab[7] + int'(TOL);
        rst    = 1'b1;
        clk_in = 1'b0;
        model_clear();
        test_reset();
        test_lock();
        test_relock();
        test_illegal();
        test_tolerance();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
